// File: rtl/bnn_pkg.sv
// ============================================================================
// Module   : bnn_pkg
// Purpose  : Shared loader state encoding and parameter-chain sizing for the
//            BNN core and its parameter loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package bnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } loader_state_e;

  localparam int c_N_IN  = 8;
  localparam int c_N_HID = 8;
  localparam int c_N_OUT = 8;
  localparam int c_THR_W = 4;

  // Two weight matrices plus one popcount threshold per hidden unit.
  localparam int c_CHAIN_BITS = c_N_IN * c_N_HID + c_N_HID * c_N_OUT + c_N_HID * c_THR_W;

endpackage

`default_nettype wire

// File: rtl/bnn_piso8.sv
// ============================================================================
// Module   : bnn_piso8
// Purpose  : 8-bit parallel-in/serial-out register, MSB first, with a
//            remaining-bit count. The presented bit holds once drained.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bnn_piso8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       shift,
  input  logic       flush,
  input  logic [7:0] din,
  output logic       ser_bit,
  output logic       valid,
  output logic       last
);

  logic [7:0] r_data;
  logic [3:0] r_rem;
  logic       r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 8'd0;
      r_rem   <= 4'd0;
      r_valid <= 1'b0;
    end else if (flush) begin
      r_rem   <= 4'd0;
      r_valid <= 1'b0;
    end else if (load) begin
      r_data  <= din;
      r_rem   <= 4'd8;
      r_valid <= 1'b1;
    end else if (shift && r_valid) begin
      // The final bit is not shifted out so the chain input stays stable.
      if (r_rem != 4'd1) begin
        r_data <= {r_data[6:0], 1'b0};
      end
      r_rem   <= r_rem - 4'd1;
      r_valid <= (r_rem != 4'd1);
    end
  end

  assign ser_bit = r_data[7];
  assign valid   = r_valid;
  assign last    = (r_rem == 4'd1);

endmodule

`default_nettype wire

// File: rtl/bnn_param_loader.sv
// ============================================================================
// Module   : bnn_param_loader
// Purpose  : Streams parameter bytes MSB-first into the BNN core's serial
//            parameter chain, stopping exactly at the chain length.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bnn_param_loader
  import bnn_pkg::*;
#(
  parameter int CHAIN_BITS = c_CHAIN_BITS,
  parameter int CNT_W      = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             param_bit,
  output logic             setup_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bits_loaded
);

  localparam logic [CNT_W-1:0] c_LAST_IDX = CNT_W'(CHAIN_BITS - 1);

  loader_state_e    r_state;
  loader_state_e    w_state_nxt;
  logic [CNT_W-1:0] r_bits;
  logic             w_ser_bit;
  logic             w_valid;
  logic             w_last;
  logic             w_ready;
  logic             w_fire;
  logic             w_term;
  logic             w_flush;
  logic             w_begin;

  // The bit being presented this cycle is number r_bits+1 of the load.
  assign w_term  = w_valid && (r_bits == c_LAST_IDX);
  assign w_fire  = byte_valid && w_ready;
  assign w_flush = abort || w_term;
  assign w_begin = (r_state == IDLE) && start && !abort;

  bnn_piso8 u_piso (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_fire),
    .shift   (w_valid),
    .flush   (w_flush),
    .din     (byte_in),
    .ser_bit (w_ser_bit),
    .valid   (w_valid),
    .last    (w_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_begin) begin
          w_state_nxt = LOAD;
        end
      end
      LOAD: begin
        busy = 1'b1;
        // Accept a new byte while the last bit of the current one goes out,
        // unless that bit is the final one of the chain.
        w_ready = !abort && (!w_valid || (w_last && (r_bits < c_LAST_IDX)));
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (w_term) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bits <= '0;
    end else if (w_begin) begin
      r_bits <= '0;
    end else if (w_valid) begin
      r_bits <= r_bits + CNT_W'(1);
    end
  end

  assign byte_ready  = w_ready;
  assign param_bit   = w_ser_bit;
  assign setup_out   = w_valid;
  assign bits_loaded = r_bits;

endmodule

`default_nettype wire

// File: tb/tb_bnn_param_loader.sv
// ============================================================================
// Module   : tb_bnn_param_loader
// Purpose  : Scoreboard bench for bnn_param_loader with 16- and 12-bit chains.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bnn_param_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, start, abort, byte_valid, sel12;
  logic [7:0] byte_in;

  logic        start_a, valid_a, ready_a, bit_a, setup_a, busy_a, done_a;
  logic        start_b, valid_b, ready_b, bit_b, setup_b, busy_b, done_b;
  logic [11:0] bits_a, bits_b;

  assign start_a = start & ~sel12;
  assign valid_a = byte_valid & ~sel12;
  assign start_b = start & sel12;
  assign valid_b = byte_valid & sel12;

  bnn_param_loader #(.CHAIN_BITS(16), .CNT_W(12)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .byte_in(byte_in),
    .byte_valid(valid_a), .byte_ready(ready_a), .param_bit(bit_a), .setup_out(setup_a),
    .busy(busy_a), .done(done_a), .bits_loaded(bits_a));

  bnn_param_loader #(.CHAIN_BITS(12), .CNT_W(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .byte_in(byte_in),
    .byte_valid(valid_b), .byte_ready(ready_b), .param_bit(bit_b), .setup_out(setup_b),
    .busy(busy_b), .done(done_b), .bits_loaded(bits_b));

  logic        obs_ready, obs_bit, obs_setup, obs_busy, obs_done;
  logic [11:0] obs_bits_loaded;
  assign obs_ready       = sel12 ? ready_b : ready_a;
  assign obs_bit         = sel12 ? bit_b   : bit_a;
  assign obs_setup       = sel12 ? setup_b : setup_a;
  assign obs_busy        = sel12 ? busy_b  : busy_a;
  assign obs_done        = sel12 ? done_b  : done_a;
  assign obs_bits_loaded = sel12 ? bits_b  : bits_a;

  int total = 0;
  int bad = 0;
  logic exp_q[$];
  logic exp_e;
  int m_pushed, chain_len;
  int cyc = 0;
  int setup_cnt, done_cnt, gap_cnt, stable_viol, first_setup_cyc, last_setup_cyc, done_cyc;
  logic [31:0] obs_bits;
  logic prev_bit;

  // Scoreboard consumer: every presented bit must match the oldest expected bit.
  always @(negedge clk) begin
    cyc++;
    if (obs_setup === 1'b1) begin
      setup_cnt++;
      if (setup_cnt == 1) first_setup_cyc = cyc;
      last_setup_cyc = cyc;
      obs_bits = {obs_bits[30:0], obs_bit};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: setup_out=1 with no expected bit, param_bit=%b", obs_bit);
      end else begin
        exp_e = exp_q.pop_front();
        if (obs_bit !== exp_e) begin
          bad++;
          $display("FAIL sb_bit: setup #%0d param_bit=%b expected %b", setup_cnt, obs_bit, exp_e);
        end
      end
    end else if (obs_busy === 1'b1 && setup_cnt > 0) begin
      gap_cnt++;
      if (obs_bit !== prev_bit) stable_viol++;
    end
    if (obs_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    prev_bit = obs_bit;
  end

  task automatic clear_stats();
    setup_cnt = 0; done_cnt = 0; gap_cnt = 0; stable_viol = 0;
    first_setup_cyc = -1; last_setup_cyc = -1; done_cyc = -1;
    obs_bits = '0;
    exp_q.delete();
    m_pushed = 0;
  endtask

  task automatic idle_all();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    clear_stats();
  endtask

  task automatic do_start();
    m_pushed  = 0;
    chain_len = sel12 ? 12 : 16;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Producer: expected bits are queued when the handshake is seen, truncated to the chain length.
  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (obs_ready === 1'b1) begin
        for (int k = 7; k >= 0; k--) begin
          if (m_pushed < chain_len) begin
            exp_q.push_back(b[k]);
            m_pushed++;
          end
        end
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    total++; bad++;
    $display("FAIL send_timeout: byte_ready never rose for byte %02h", b);
  endtask

  task automatic test_reset();
    sel12 = 1'b0; rst_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
    clear_stats();
    #3;
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", obs_ready); end
    total++; if (obs_bit !== 1'b0) begin bad++; $display("FAIL rst_param_bit: got %b want 0", obs_bit); end
    total++; if (obs_setup !== 1'b0) begin bad++; $display("FAIL rst_setup: got %b want 0", obs_setup); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", obs_busy); end
    total++; if (obs_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", obs_done); end
    total++; if (obs_bits_loaded !== 12'd0) begin bad++; $display("FAIL rst_bits: got %0d want 0", obs_bits_loaded); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_burst16();
    sel12 = 1'b0;
    idle_all();
    do_start();
    send_byte(8'hA5);
    send_byte(8'h3C);
    byte_valid = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (setup_cnt != 16) begin bad++; $display("FAIL b16_setup_cnt: got %0d want 16", setup_cnt); end
    total++; if (last_setup_cyc - first_setup_cyc + 1 != 16) begin bad++; $display("FAIL b16_contiguous: span %0d want 16", last_setup_cyc - first_setup_cyc + 1); end
    total++; if (obs_bits[15:0] !== 16'hA53C) begin bad++; $display("FAIL b16_bits: got %h want a53c", obs_bits[15:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL b16_done_cnt: got %0d want 1", done_cnt); end
    total++; if (done_cyc != last_setup_cyc + 1) begin bad++; $display("FAIL b16_done_time: got cyc %0d want %0d", done_cyc, last_setup_cyc + 1); end
    total++; if (obs_bits_loaded !== 12'd16) begin bad++; $display("FAIL b16_bits_loaded: got %0d want 16", obs_bits_loaded); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b16_leftover: got %0d bits pending want 0", exp_q.size()); end
  endtask

  task automatic test_trunc12();
    sel12 = 1'b1;
    idle_all();
    do_start();
    send_byte(8'hFF);
    send_byte(8'h0F);
    #1;
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL t12_ready_after: got %b want 0", obs_ready); end
    repeat (6) @(negedge clk);
    #1;
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL t12_ready_held: got %b want 0", obs_ready); end
    byte_valid = 1'b0;
    repeat (15) @(negedge clk);
    total++; if (setup_cnt != 12) begin bad++; $display("FAIL t12_setup_cnt: got %0d want 12", setup_cnt); end
    total++; if (obs_bits[11:0] !== 12'hFF0) begin bad++; $display("FAIL t12_bits: got %h want ff0", obs_bits[11:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL t12_done_cnt: got %0d want 1", done_cnt); end
    total++; if (obs_bits_loaded !== 12'd12) begin bad++; $display("FAIL t12_bits_loaded: got %0d want 12", obs_bits_loaded); end
    sel12 = 1'b0;
  endtask

  task automatic test_starve();
    sel12 = 1'b0;
    idle_all();
    do_start();
    send_byte(8'h81);
    byte_valid = 1'b0;
    repeat (12) @(negedge clk);
    send_byte(8'h81);
    byte_valid = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (gap_cnt != 5) begin bad++; $display("FAIL st_gap: got %0d want 5", gap_cnt); end
    total++; if (stable_viol != 0) begin bad++; $display("FAIL st_stable: got %0d changes want 0", stable_viol); end
    total++; if (setup_cnt != 16) begin bad++; $display("FAIL st_setup_cnt: got %0d want 16", setup_cnt); end
    total++; if (obs_bits[15:0] !== 16'h8181) begin bad++; $display("FAIL st_bits: got %h want 8181", obs_bits[15:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL st_done_cnt: got %0d want 1", done_cnt); end
  endtask

  task automatic test_abort();
    sel12 = 1'b0;
    idle_all();
    do_start();
    send_byte(8'hF0);
    byte_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL ab_busy: got %b want 0", obs_busy); end
    total++; if (obs_setup !== 1'b0) begin bad++; $display("FAIL ab_setup: got %b want 0", obs_setup); end
    total++; if (obs_bits_loaded !== 12'd5) begin bad++; $display("FAIL ab_bits: got %0d want 5", obs_bits_loaded); end
    exp_q.delete();
    repeat (10) @(negedge clk);
    total++; if (done_cnt != 0) begin bad++; $display("FAIL ab_no_done: got %0d want 0", done_cnt); end
    total++; if (setup_cnt != 5) begin bad++; $display("FAIL ab_setup_cnt: got %0d want 5", setup_cnt); end
    total++; if (obs_bits[4:0] !== 5'b11110) begin bad++; $display("FAIL ab_seq: got %b want 11110", obs_bits[4:0]); end
    total++; if (obs_bits_loaded !== 12'd5) begin bad++; $display("FAIL ab_bits_hold: got %0d want 5", obs_bits_loaded); end
    clear_stats();
    do_start();
    total++; if (obs_bits_loaded !== 12'd0) begin bad++; $display("FAIL ab_restart_clr: got %0d want 0", obs_bits_loaded); end
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL ab_restart_busy: got %b want 1", obs_busy); end
    send_byte(8'h5A);
    send_byte(8'hC3);
    byte_valid = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (setup_cnt != 16) begin bad++; $display("FAIL ab_reload_cnt: got %0d want 16", setup_cnt); end
    total++; if (obs_bits[15:0] !== 16'h5AC3) begin bad++; $display("FAIL ab_reload_bits: got %h want 5ac3", obs_bits[15:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ab_reload_done: got %0d want 1", done_cnt); end
    total++; if (obs_bits_loaded !== 12'd16) begin bad++; $display("FAIL ab_reload_bits_loaded: got %0d want 16", obs_bits_loaded); end
  endtask

  task automatic test_async_reset();
    sel12 = 1'b0;
    idle_all();
    do_start();
    send_byte(8'h6E);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (obs_setup !== 1'b0) begin bad++; $display("FAIL ar_setup: got %b want 0", obs_setup); end
    total++; if (obs_bit !== 1'b0) begin bad++; $display("FAIL ar_param_bit: got %b want 0", obs_bit); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL ar_busy: got %b want 0", obs_busy); end
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL ar_ready: got %b want 0", obs_ready); end
    total++; if (obs_done !== 1'b0) begin bad++; $display("FAIL ar_done: got %b want 0", obs_done); end
    total++; if (obs_bits_loaded !== 12'd0) begin bad++; $display("FAIL ar_bits: got %0d want 0", obs_bits_loaded); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_stats();
    do_start();
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL ar_restart_busy: got %b want 1", obs_busy); end
    total++; if (obs_bits_loaded !== 12'd0) begin bad++; $display("FAIL ar_restart_bits: got %0d want 0", obs_bits_loaded); end
  endtask

  task automatic test_ignored();
    sel12 = 1'b0;
    idle_all();
    byte_in    = 8'hFF;
    byte_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (obs_ready !== 1'b0) begin bad++; $display("FAIL ig_idle_ready: got %b want 0", obs_ready); end
    total++; if (obs_busy !== 1'b0) begin bad++; $display("FAIL ig_idle_busy: got %b want 0", obs_busy); end
    total++; if (setup_cnt != 0) begin bad++; $display("FAIL ig_idle_xfer: got %0d setup cycles want 0", setup_cnt); end
    byte_valid = 1'b0;
    @(negedge clk);
    do_start();
    send_byte(8'hA5);
    byte_valid = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if (obs_bits_loaded !== 12'd3) begin bad++; $display("FAIL ig_start_bits: got %0d want 3", obs_bits_loaded); end
    total++; if (obs_busy !== 1'b1) begin bad++; $display("FAIL ig_start_busy: got %b want 1", obs_busy); end
    send_byte(8'h3C);
    byte_valid = 1'b0;
    repeat (20) @(negedge clk);
    total++; if (setup_cnt != 16) begin bad++; $display("FAIL ig_setup_cnt: got %0d want 16", setup_cnt); end
    total++; if (obs_bits[15:0] !== 16'hA53C) begin bad++; $display("FAIL ig_bits: got %h want a53c", obs_bits[15:0]); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL ig_done_cnt: got %0d want 1", done_cnt); end
    total++; if (obs_bits_loaded !== 12'd16) begin bad++; $display("FAIL ig_bits_loaded: got %0d want 16", obs_bits_loaded); end
  endtask

  initial begin
    test_reset();
    test_burst16();
    test_trunc12();
    test_starve();
    test_abort();
    test_async_reset();
    test_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
